// File: rtl/ili934x_item_arb.sv
// Packet-level round-robin arbiter merging N_REQ wr_item_t streams into one.
// Optional stall timeout is enabled by defining ITEM_ARB_TIMEOUT_EN.
package ili934x_pkg;
    typedef struct packed {
        logic       is_cmd;
        logic [7:0] data;
    } wr_item_t;
endpackage

module ili934x_item_arb
    import ili934x_pkg::*;
#(
    parameter  int N_REQ       = 3,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int GW          = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic     [N_REQ-1:0]   req_valid,
    input  wr_item_t [N_REQ-1:0]   req_item,
    input  logic     [N_REQ-1:0]   req_last,
    output logic     [N_REQ-1:0]   req_ready,
    output logic                   item_valid,
    output wr_item_t               item,
    input  logic                   item_ready,
    output logic                   busy,
    output logic     [GW-1:0]      grant_id,
    output logic                   timeout_err
);

    typedef enum logic {
        A_IDLE,
        A_GRANT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [GW-1:0] r_ptr;
    logic [GW-1:0] w_ptr_nxt;
    logic [GW-1:0] r_gid;
    logic [GW-1:0] w_gid_nxt;
    logic [GW-1:0] w_pick;
    logic [GW-1:0] w_adv;
    logic [GW-1:0] w_idx [N_REQ];
    logic          w_any;
    logic          w_gvalid;
    logic          w_xfer;
    logic          w_hit;
    logic          r_tmo;
    logic          w_tmo_nxt;

    // Search order ptr, ptr+1, ... wrapping; loop runs backwards so the
    // nearest candidate to ptr is written last and wins.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_idx[i] = GW'((int'(r_ptr) + i) % N_REQ);
        end
    end

    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[w_idx[i]]) begin
                w_pick = w_idx[i];
                w_any  = 1'b1;
            end
        end
    end

    assign w_gvalid = req_valid[r_gid];
    assign w_adv    = (r_gid == GW'(N_REQ - 1)) ? '0 : r_gid + 1'b1;

`ifdef ITEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;

    assign w_hit = (r_state == A_GRANT) && !w_gvalid
                && (r_cnt == CW'(TIMEOUT_CYC - 1));

    // Only starvation by the granted source counts; FIFO back-pressure never does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state != A_GRANT || w_xfer) begin
            r_cnt <= '0;
        end else if (!w_gvalid) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gid_nxt   = r_gid;
        w_tmo_nxt   = 1'b0;
        w_xfer      = 1'b0;
        item_valid  = 1'b0;
        item        = '0;
        req_ready   = '0;
        unique case (r_state)
            A_IDLE: begin
                if (w_any) begin
                    w_gid_nxt   = w_pick;
                    w_state_nxt = A_GRANT;
                end
            end
            A_GRANT: begin
                item_valid       = w_gvalid;
                item             = w_gvalid ? req_item[r_gid] : '0;
                req_ready[r_gid] = item_ready;
                w_xfer           = w_gvalid && item_ready;
                if (w_xfer && req_last[r_gid]) begin
                    w_state_nxt = A_IDLE;
                    w_ptr_nxt   = w_adv;
                end else if (w_hit) begin
                    w_state_nxt = A_IDLE;
                    w_ptr_nxt   = w_adv;
                    w_tmo_nxt   = 1'b1;
                end
            end
            default: w_state_nxt = A_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= A_IDLE;
            r_ptr   <= '0;
            r_gid   <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gid   <= w_gid_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    assign busy        = (r_state == A_GRANT);
    assign grant_id    = r_gid;
    assign timeout_err = r_tmo;

endmodule
